button_conditioner: RTL and testbench
=====================================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, sets consecutive stable clk cycles needed to accept a raw level change (10 ms at 50 MHz).
REQ-002 Parameter LONG_PRESS_CYCLES, default 250000000, sets debounced-held clk cycles needed for a long press (5 s at 50 MHz).
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 raw_salud, raw_energia, raw_hambre, raw_diversion, raw_reset, raw_test  input  1 each  asynchronous board buttons, active-low (0 = pressed).
REQ-006 btn_salud, btn_energia, btn_hambre, btn_diversion  output  1 each  one-cycle active-high press pulses to tamagotchi_fsm.
REQ-007 btn_reset, btn_test  output  1 each  one-cycle active-high pulses to tamagotchi_fsm, timing per REQ-016/REQ-022.
REQ-008 btn_held  output  6  debounced pressed levels, bit order {test, reset, diversion, hambre, energia, salud}.

Function
REQ-009 Each raw input SHALL pass through a 2-flop synchronizer, then be inverted to active-high before any other logic.
REQ-010 Each channel SHALL keep a debounced state and a counter of width $clog2(DEBOUNCE_CYCLES+1).
REQ-011 Counter SHALL increment each cycle the synchronized sample differs from the debounced state, and clear to 0 on any cycle they match.
REQ-012 When the counter reaches DEBOUNCE_CYCLES, the debounced state SHALL take the sample value and the counter SHALL clear in the same cycle.
REQ-013 A glitch shorter than DEBOUNCE_CYCLES cycles SHALL produce no change in btn_held and no pulse.
REQ-014 Action channels (salud, energia, hambre, diversion) SHALL pulse for exactly one cycle, in the cycle after their debounced state goes 0->1.
REQ-015 Press-to-pulse latency SHALL be 2 (sync) + DEBOUNCE_CYCLES + 1 cycles; release SHALL never produce a pulse.
REQ-016 With BTN_LONG_PRESS_EN, reset and test channels SHALL each run a hold counter of width $clog2(LONG_PRESS_CYCLES+1) that increments while debounced-pressed and clears when debounced-released.
REQ-017 The hold counter SHALL pulse its output once, in the cycle after the counter reaches LONG_PRESS_CYCLES, then saturate with no repeat until release.
REQ-018 Per-channel FSM for reset/test: IDLE -> (debounced press) HOLDING -> (count = LONG_PRESS_CYCLES) FIRED -> (debounced release) IDLE; HOLDING -> (debounced release) IDLE with no pulse.
REQ-019 Channels SHALL be fully independent: simultaneous presses produce simultaneous pulses; there is no priority or masking.

Reset
REQ-020 While reset is high: all synchronizer flops = 0 (released), debounced states = 0, counters = 0, FSMs = IDLE, and all outputs = 0.
REQ-021 Reset asserted mid-debounce or mid-hold SHALL abort the operation with no pulse. A button held across reset release SHALL be treated as a new press, pulsing after the REQ-015 latency (action channels) or the full long press (reset/test).

Configuration
REQ-022 Macro BTN_LONG_PRESS_EN. Defined: reset/test behave per REQ-016..REQ-018. Undefined: reset/test behave exactly as action channels (REQ-014), hold counters and FSMs are absent, and LONG_PRESS_CYCLES is unused.

Verification (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10)
REQ-023 raw_salud low at cycle 0 and held -> btn_held[0]=1 and a single btn_salud pulse at cycle 7; release -> no pulse, btn_held[0]=0 after 7 cycles.
REQ-024 raw_hambre low for 3 cycles, then high -> btn_hambre and btn_held[2] stay 0 throughout.
REQ-025 raw_energia and raw_diversion low in the same cycle -> btn_energia and btn_diversion pulse in the same cycle (cycle 7).
REQ-026 With macro: raw_test held 30 cycles -> exactly one btn_test pulse, 10 cycles after btn_held[5] rises; raw_reset held only 8 cycles past debounce -> no btn_reset pulse. Without macro: raw_test low -> btn_test pulse at cycle 7.
REQ-027 raw_salud low, reset pulsed at cycle 3 for 1 cycle, raw_salud still held -> no pulse before reset; one btn_salud pulse 7 cycles after reset deasserts.

Source files
------------

// File: rtl/button_conditioner.sv
// Conditions six active-low board buttons into debounced levels and one-cycle press pulses.
// Define BTN_LONG_PRESS_EN to make the reset/test channels fire only after a long hold.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES   = 500000,
    parameter int LONG_PRESS_CYCLES = 250000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       raw_salud,
    input  logic       raw_energia,
    input  logic       raw_hambre,
    input  logic       raw_diversion,
    input  logic       raw_reset,
    input  logic       raw_test,
    output logic       btn_salud,
    output logic       btn_energia,
    output logic       btn_hambre,
    output logic       btn_diversion,
    output logic       btn_reset,
    output logic       btn_test,
    output logic [5:0] btn_held
);

    localparam int NUM_CH = 6;
    localparam int DW     = $clog2(DEBOUNCE_CYCLES + 1);
`ifdef BTN_LONG_PRESS_EN
    localparam int EDGE_CH = 4;
    localparam int HW      = $clog2(LONG_PRESS_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, HOLDING, FIRED} hold_state_t;
`else
    localparam int EDGE_CH = NUM_CH;
`endif

    if (DEBOUNCE_CYCLES < 1 || LONG_PRESS_CYCLES < 1) begin : g_param_check
        $error("button_conditioner: cycle parameters must be at least 1");
    end

    logic [NUM_CH-1:0] raw_vec;
    logic [NUM_CH-1:0] pressed_raw;
    logic [NUM_CH-1:0] sync1_reg;
    logic [NUM_CH-1:0] sync2_reg;
    logic [NUM_CH-1:0] deb_reg;
    logic [NUM_CH-1:0] pulse;

    assign raw_vec     = {raw_test, raw_reset, raw_diversion, raw_hambre, raw_energia, raw_salud};
    // Inverting ahead of the first flop is equivalent to inverting after the
    // chain, and lets every flop reset to 0 meaning "released".
    assign pressed_raw = ~raw_vec;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= pressed_raw;
            sync2_reg <= sync1_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_debounce
            logic [DW-1:0] cnt_reg;
            logic [DW-1:0] cnt_inc;

            assign cnt_inc = cnt_reg + DW'(1);

            // Accept the new level on the cycle the mismatch count hits the limit.
            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_reg    <= '0;
                    deb_reg[gi] <= 1'b0;
                end else if (sync2_reg[gi] == deb_reg[gi]) begin
                    cnt_reg <= '0;
                end else if (cnt_inc == DW'(DEBOUNCE_CYCLES)) begin
                    cnt_reg    <= '0;
                    deb_reg[gi] <= sync2_reg[gi];
                end else begin
                    cnt_reg <= cnt_inc;
                end
            end
        end

        for (gi = 0; gi < EDGE_CH; gi++) begin : g_edge
            logic deb_prev_reg;
            logic pulse_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    deb_prev_reg <= 1'b0;
                    pulse_reg    <= 1'b0;
                end else begin
                    deb_prev_reg <= deb_reg[gi];
                    pulse_reg    <= deb_reg[gi] & ~deb_prev_reg;
                end
            end

            assign pulse[gi] = pulse_reg;
        end

`ifdef BTN_LONG_PRESS_EN
        for (gi = EDGE_CH; gi < NUM_CH; gi++) begin : g_long
            hold_state_t   state_reg;
            hold_state_t   state_next;
            logic [HW-1:0] hold_cnt_reg;
            logic [HW-1:0] hold_cnt_next;
            logic          fire;

            always_ff @(posedge clk) begin
                if (reset) begin
                    state_reg    <= IDLE;
                    hold_cnt_reg <= '0;
                end else begin
                    state_reg    <= state_next;
                    hold_cnt_reg <= hold_cnt_next;
                end
            end

            always_comb begin
                state_next    = state_reg;
                hold_cnt_next = hold_cnt_reg;
                fire          = 1'b0;

                // Counter saturates at the limit so a long hold never repeats.
                if (!deb_reg[gi]) begin
                    hold_cnt_next = '0;
                end else if (hold_cnt_reg != HW'(LONG_PRESS_CYCLES)) begin
                    hold_cnt_next = hold_cnt_reg + HW'(1);
                end

                case (state_reg)
                    IDLE: begin
                        if (deb_reg[gi]) begin
                            state_next = HOLDING;
                        end
                    end
                    HOLDING: begin
                        if (hold_cnt_reg == HW'(LONG_PRESS_CYCLES)) begin
                            fire       = 1'b1;
                            state_next = FIRED;
                        end else if (!deb_reg[gi]) begin
                            state_next = IDLE;
                        end
                    end
                    FIRED: begin
                        if (!deb_reg[gi]) begin
                            state_next = IDLE;
                        end
                    end
                    default: state_next = IDLE;
                endcase
            end

            assign pulse[gi] = fire;
        end
`endif
    endgenerate

    assign btn_salud     = pulse[0];
    assign btn_energia   = pulse[1];
    assign btn_hambre    = pulse[2];
    assign btn_diversion = pulse[3];
    assign btn_reset     = pulse[4];
    assign btn_test      = pulse[5];
    assign btn_held      = deb_reg;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed self-checking bench for button_conditioner (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10).
// Cycle n means the state just after the n-th rising edge following a stimulus change.
module tb_button_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic       raw_salud, raw_energia, raw_hambre, raw_diversion, raw_reset, raw_test;
    logic       btn_salud, btn_energia, btn_hambre, btn_diversion, btn_reset, btn_test;
    logic [5:0] btn_held;

    int         tests = 0;
    int         fails = 0;
    int         cyc;
    int         pcnt[6];
    int         pcyc[6];
    int         hrise[6];
    logic [5:0] held_acc;
    logic [5:0] pvec;

    button_conditioner #(
        .DEBOUNCE_CYCLES  (4),
        .LONG_PRESS_CYCLES(10)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .raw_salud    (raw_salud),
        .raw_energia  (raw_energia),
        .raw_hambre   (raw_hambre),
        .raw_diversion(raw_diversion),
        .raw_reset    (raw_reset),
        .raw_test     (raw_test),
        .btn_salud    (btn_salud),
        .btn_energia  (btn_energia),
        .btn_hambre   (btn_hambre),
        .btn_diversion(btn_diversion),
        .btn_reset    (btn_reset),
        .btn_test     (btn_test),
        .btn_held     (btn_held)
    );

    always #5 clk = ~clk;

    assign pvec = {btn_test, btn_reset, btn_diversion, btn_hambre, btn_energia, btn_salud};

    task automatic chk(input string tag, input int observed, input int expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
        $display("[TB] check %-22s observed=%0d expected=%0d", tag, observed, expected);
    endtask

    task automatic clear_stats();
        cyc      = 0;
        held_acc = '0;
        for (int i = 0; i < 6; i++) begin
            pcnt[i]  = 0;
            pcyc[i]  = -1;
            hrise[i] = -1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        held_acc = held_acc | btn_held;
        for (int i = 0; i < 6; i++) begin
            if (pvec[i]) begin
                pcnt[i]++;
                pcyc[i] = cyc;
            end
            if (btn_held[i] && hrise[i] < 0) hrise[i] = cyc;
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        reset         = 1'b1;
        raw_salud     = 1'b1;
        raw_energia   = 1'b1;
        raw_hambre    = 1'b1;
        raw_diversion = 1'b1;
        raw_reset     = 1'b1;
        raw_test      = 1'b1;
        clear_stats();

        // Reset state
        run(3);
        chk("reset_held", int'(btn_held), 0);
        chk("reset_pulses", int'(pvec), 0);
        reset = 1'b0;
        run(3);
        chk("idle_held", int'(btn_held), 0);

        // Single press on salud, then release
        clear_stats();
        raw_salud = 1'b0;
        run(5);
        chk("salud_held_c5", int'(btn_held[0]), 0);
        run(1);
        chk("salud_held_c6", int'(btn_held[0]), 1);
        chk("salud_no_early_pulse", pcnt[0], 0);
        run(1);
        chk("salud_pulse_c7", int'(btn_salud), 1);
        run(10);
        chk("salud_pulse_count", pcnt[0], 1);
        chk("salud_pulse_cycle", pcyc[0], 7);
        clear_stats();
        raw_salud = 1'b1;
        run(5);
        chk("salud_rel_held_c5", int'(btn_held[0]), 1);
        run(2);
        chk("salud_rel_held_c7", int'(btn_held[0]), 0);
        run(10);
        chk("salud_rel_no_pulse", pcnt[0], 0);

        // Glitch on hambre shorter than the debounce window
        clear_stats();
        raw_hambre = 1'b0;
        run(3);
        raw_hambre = 1'b1;
        run(15);
        chk("hambre_glitch_held", int'(held_acc[2]), 0);
        chk("hambre_glitch_pulse", pcnt[2], 0);

        // Simultaneous presses are independent
        clear_stats();
        raw_energia   = 1'b0;
        raw_diversion = 1'b0;
        run(15);
        chk("energia_pulse_cycle", pcyc[1], 7);
        chk("diversion_pulse_cycle", pcyc[3], 7);
        chk("energia_pulse_count", pcnt[1], 1);
        chk("diversion_pulse_count", pcnt[3], 1);
        chk("other_channels_quiet", pcnt[0] + pcnt[2] + pcnt[4] + pcnt[5], 0);
        raw_energia   = 1'b1;
        raw_diversion = 1'b1;
        run(12);

`ifdef BTN_LONG_PRESS_EN
        // Long hold on test fires once, ten cycles after the debounced level rises
        clear_stats();
        raw_test = 1'b0;
        run(30);
        raw_test = 1'b1;
        run(12);
        chk("test_held_rise", hrise[5], 6);
        chk("test_long_count", pcnt[5], 1);
        chk("test_long_cycle", pcyc[5], 16);
        // Short hold on reset aborts without a pulse
        clear_stats();
        raw_reset = 1'b0;
        run(8);
        raw_reset = 1'b1;
        run(15);
        chk("reset_short_held", int'(held_acc[4]), 1);
        chk("reset_short_no_pulse", pcnt[4], 0);
`else
        clear_stats();
        raw_test = 1'b0;
        run(12);
        chk("test_pulse_count", pcnt[5], 1);
        chk("test_pulse_cycle", pcyc[5], 7);
        raw_test = 1'b1;
        run(12);
        chk("test_rel_no_pulse", pcnt[5], 1);
        clear_stats();
        raw_reset = 1'b0;
        run(12);
        chk("btnreset_pulse_cycle", pcyc[4], 7);
        raw_reset = 1'b1;
        run(12);
        chk("btnreset_pulse_count", pcnt[4], 1);
`endif

        // Reset mid-debounce aborts; a held button is a fresh press afterwards
        clear_stats();
        raw_salud = 1'b0;
        run(2);
        reset = 1'b1;
        run(1);
        chk("midrst_held", int'(btn_held), 0);
        chk("midrst_pulses", int'(pvec), 0);
        reset = 1'b0;
        run(15);
        chk("midrst_pulse_count", pcnt[0], 1);
        chk("midrst_pulse_cycle", pcyc[0], 10);
        raw_salud = 1'b1;
        run(12);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
